// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receiver state encoding and the expected-parity helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } rx_state_t;

    // Callers zero-extend narrower words; extra zeros leave the XOR unchanged.
    function automatic logic expected_parity(input logic [8:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser and bit sampler for uart_rx_cfg. With UART_RX_MAJORITY_EN
// defined, each requested sample is a 2-of-3 vote delivered one cycle later.
module uart_rx_sampler (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic rx_serial,
    input  logic sample_req,
    output logic rx_s,
    output logic sample_bit,
    output logic sample_vld
);

    logic sync_1;
    logic sync_2;

    // NOTE: non-blocking assignments make the two stages shift on the same edge instead of collapsing into one.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= rx_serial;
            sync_2 <= sync_1;
        end
    end

    assign rx_s = sync_2;

`ifdef UART_RX_MAJORITY_EN
    logic rx_d;
    logic vote_a;
    logic vote_b;
    logic vote_vld;

    // vote_a/vote_b hold the sample-1 and sample values; sample+1 is rx_s now.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_d     <= 1'b1;
            vote_a   <= 1'b1;
            vote_b   <= 1'b1;
            vote_vld <= 1'b0;
        end else begin
            rx_d     <= rx_s;
            vote_vld <= sample_req;
            if (sample_req) begin
                vote_a <= rx_d;
                vote_b <= rx_s;
            end
        end
    end

    assign sample_bit = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
    assign sample_vld = vote_vld;
`else
    assign sample_bit = rx_s;
    assign sample_vld = sample_req;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver (5-9 data bits, none/odd/even parity, 1-2 stop bits)
// with parity, framing and break reporting. Optional feature macro: UART_RX_MAJORITY_EN.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $fatal(1, "uart_rx_cfg: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_rx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
        $fatal(1, "uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $fatal(1, "uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int MID   = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(MID);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);
    localparam bit               HAS_PARITY = (PARITY != PARITY_NONE);

    rx_state_t            state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 par_err;
    logic                 frm_err;

    logic rx_s;
    logic sample_req;
    logic sample_bit;
    logic sample_vld;

    uart_rx_sampler u_sampler (
        .i_Clock    (i_Clock),
        .i_Rst_L    (i_Rst_L),
        .rx_serial  (i_RX_Serial),
        .sample_req (sample_req),
        .rx_s       (rx_s),
        .sample_bit (sample_bit),
        .sample_vld (sample_vld)
    );

    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    always_comb begin
        sample_req = 1'b0;
        case (state)
            S_START:                    sample_req = (clk_cnt == START_LAST);
            S_DATA, S_PARITY, S_STOP:   sample_req = (clk_cnt == BIT_LAST);
            default:                    sample_req = 1'b0;
        endcase
    end

    // The bit clock free-runs from the start edge; acting on sample_vld rather
    // than the count lets the voted sample arrive late without skewing later bits.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= S_IDLE;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shift        <= '0;
            par_bit      <= 1'b0;
            par_err      <= 1'b0;
            frm_err      <= 1'b0;
            o_RX_DV      <= 1'b0;
            o_RX_Data    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;
            if (sample_req) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    clk_cnt  <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    if (!rx_s) begin
                        // The detection cycle is count 0 of the half-bit wait.
                        state   <= S_START;
                        clk_cnt <= CNT_W'(1);
                        par_bit <= 1'b0;
                        par_err <= 1'b0;
                        frm_err <= 1'b0;
                    end
                end

                S_START: begin
                    if (sample_vld) begin
                        if (sample_bit) begin
                            state   <= S_IDLE;
                            clk_cnt <= '0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (sample_vld) begin
                        shift[bit_idx] <= sample_bit;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            state   <= HAS_PARITY ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

                S_PARITY: begin
                    if (sample_vld) begin
                        par_bit <= sample_bit;
                        par_err <= (sample_bit != expected_parity(9'(shift), PARITY));
                        state   <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (sample_vld) begin
                        if (!stop_idx && !sample_bit && shift == '0 && !par_bit) begin
                            o_RX_DV      <= 1'b1;
                            o_RX_Data    <= shift;
                            o_Parity_Err <= par_err;
                            o_Frame_Err  <= 1'b1;
                            o_Break      <= 1'b1;
                            state        <= S_BREAK_WAIT;
                            clk_cnt      <= '0;
                        end else if (stop_idx == STOP_LAST) begin
                            o_RX_DV      <= 1'b1;
                            o_RX_Data    <= shift;
                            o_Parity_Err <= par_err;
                            o_Frame_Err  <= frm_err | !sample_bit;
                            o_Break      <= 1'b0;
                            state        <= S_IDLE;
                            clk_cnt      <= '0;
                        end else begin
                            frm_err  <= frm_err | !sample_bit;
                            stop_idx <= 1'b1;
                        end
                    end
                end

                S_BREAK_WAIT: begin
                    clk_cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    clk_cnt <= '0;
                end
            endcase
        end
    end

    assign o_Busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) at 16 clocks
// per bit, driven by hand-built frames with hand-computed expectations.
module tb_uart_rx_cfg;

    localparam int CPB = 16;
    localparam int MID = (CPB - 1) / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic line [3];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       dv_a, pe_a, fe_a, brk_a, busy_a;
    logic [7:0] data_a;
    logic       dv_b, pe_b, fe_b, brk_b, busy_b;
    logic [7:0] data_b;
    logic       dv_c, pe_c, fe_c, brk_c, busy_c;
    logic [6:0] data_c;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(line[0]),
        .o_RX_DV(dv_a), .o_RX_Data(data_a), .o_Parity_Err(pe_a),
        .o_Frame_Err(fe_a), .o_Break(brk_a), .o_Busy(busy_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(line[1]),
        .o_RX_DV(dv_b), .o_RX_Data(data_b), .o_Parity_Err(pe_b),
        .o_Frame_Err(fe_b), .o_Break(brk_b), .o_Busy(busy_b)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(line[2]),
        .o_RX_DV(dv_c), .o_RX_Data(data_c), .o_Parity_Err(pe_c),
        .o_Frame_Err(fe_c), .o_Break(brk_c), .o_Busy(busy_c)
    );

    // Strobe log entry: {break, frame_err, parity_err, data zero-extended to 9 bits}.
    logic [11:0] log_a[$];
    logic [11:0] log_b[$];
    logic [11:0] log_c[$];
    int stb_cyc_a = -1;

    always @(negedge clk) begin
        if (dv_a) begin
            log_a.push_back({brk_a, fe_a, pe_a, 1'b0, data_a});
            stb_cyc_a = cyc;
        end
        if (dv_b) log_b.push_back({brk_b, fe_b, pe_b, 1'b0, data_b});
        if (dv_c) log_c.push_back({brk_c, fe_c, pe_c, 2'b00, data_c});
    end

    function automatic logic [11:0] entry(input int w, input int i);
        logic [11:0] none;
        none = 'x;
        case (w)
            0:       return (i < log_a.size()) ? log_a[i] : none;
            1:       return (i < log_b.size()) ? log_b[i] : none;
            default: return (i < log_c.size()) ? log_c[i] : none;
        endcase
    endfunction

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives n bits LSB first, one bit period each, starting at the current negedge.
    task automatic send(input int w, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            line[w] = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    int fall;

    initial begin
        line[0] = 1'b1;
        line[1] = 1'b1;
        line[2] = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_dv_a",   dv_a,   1'b0);
        check("rst_data_a", data_a, 8'h00);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_flags_b", {brk_b, fe_b, pe_b}, 3'b000);
        check("rst_data_c", data_c, 7'h00);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy_a", busy_a, 1'b0);

        // 8N1 0xA5: data, clean flags and strobe latency 2 + 8 + 9*16.
        fall = cyc;
        send(0, {1'b1, 8'hA5, 1'b0}, 10);
        repeat (4) @(negedge clk);
        check("t1_count",   log_a.size(), 1);
        check("t1_frame",   entry(0, 0), {3'b000, 1'b0, 8'hA5});
        check("t1_latency", stb_cyc_a - fall, 154);
        check("t1_hold",    data_a, 8'hA5);
        check("t1_busy",    busy_a, 1'b0);

        // 8E1 0x03 with parity bit 1 (even parity of 0x03 is 0).
        send(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
        repeat (4) @(negedge clk);
        check("t2_count", log_b.size(), 1);
        check("t2_frame", entry(1, 0), {3'b001, 1'b0, 8'h03});
        check("t2_hold",  {fe_b, pe_b}, 2'b01);

        // 7O2 0x55 with correct odd parity 1, second stop bit low past its centre.
        send(2, {1'b1, 1'b1, 7'h55, 1'b0}, 10);
        line[2] = 1'b0;
        repeat (8) @(negedge clk);
        line[2] = 1'b1;
        repeat (20) @(negedge clk);
        check("t3_count", log_c.size(), 1);
        check("t3_frame", entry(2, 0), {3'b010, 2'b00, 7'h55});
        check("t3_busy",  busy_c, 1'b0);

        // Break: line low for 20 bit times, then high, then a normal 0x3C frame.
        line[0] = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        check("t4_busy_held", busy_a, 1'b1);
        check("t4_count",     log_a.size(), 2);
        check("t4_frame",     entry(0, 1), {3'b110, 1'b0, 8'h00});
        line[0] = 1'b1;
        repeat (CPB) @(negedge clk);
        check("t4_busy_release", busy_a, 1'b0);
        check("t4_break_hold",   {brk_a, fe_a}, 2'b11);
        send(0, {1'b1, 8'h3C, 1'b0}, 10);
        repeat (4) @(negedge clk);
        check("t4_next_count", log_a.size(), 3);
        check("t4_next_frame", entry(0, 2), {3'b000, 1'b0, 8'h3C});

        // Three-clock glitch on the idle line is rejected.
        line[0] = 1'b0;
        repeat (3) @(negedge clk);
        line[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_glitch_busy", busy_a, 1'b1);
        repeat (MID + 1) @(negedge clk);
        check("t5_glitch_idle",  busy_a, 1'b0);
        check("t5_glitch_count", log_a.size(), 3);

        // Three back-to-back frames with no idle gap.
        send(0, {1'b1, 8'h00, 1'b0}, 10);
        send(0, {1'b1, 8'hFF, 1'b0}, 10);
        send(0, {1'b1, 8'h81, 1'b0}, 10);
        repeat (4) @(negedge clk);
        check("t5_b2b_count", log_a.size(), 6);
        check("t5_b2b_0",     entry(0, 3), {3'b000, 1'b0, 8'h00});
        check("t5_b2b_1",     entry(0, 4), {3'b000, 1'b0, 8'hFF});
        check("t5_b2b_2",     entry(0, 5), {3'b000, 1'b0, 8'h81});

        // Reset in the middle of data bit 4 clears everything, no strobe.
        send(0, {4'hA, 1'b0}, 5);
        line[0] = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_busy_before", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy_a", busy_a, 1'b0);
        check("t6_rst_data_a", data_a, 8'h00);
        check("t6_rst_pe_b",   pe_b,   1'b0);
        check("t6_rst_fe_c",   fe_c,   1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_no_strobe", log_a.size(), 6);
        send(0, {1'b1, 8'h7E, 1'b0}, 10);
        repeat (4) @(negedge clk);
        check("t6_count", log_a.size(), 7);
        check("t6_frame", entry(0, 6), {3'b000, 1'b0, 8'h7E});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
